sprite_line_fetch: RTL and testbench

Initiator side of the sprite ROM read interface. During horizontal blanking it walks one 32-pixel sprite row out of a 1-cycle-latency registered ROM into an internal line buffer. During active video it returns the colour index for the current draw_x. It sits between the VGA timing/draw logic and any sprite ROM (mario, brick, block) and hides the ROM latency and addressing from the colour mapper.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_line_buf.sv | 32 +++
 rtl/sprite_line_fetch.sv | 137 +++++++++++++
 tb/tb_sprite_line_fetch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite line fetch path.
// Used by sprite_line_fetch and sprite_line_buf.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  localparam int SPR_W_DEF       = 32;
  localparam int SPR_H_DEF       = 32;
  localparam int PIX_W_DEF       = 3;
  localparam int TRANSPARENT_IDX = 0;

  // True when a signed row/column offset lands inside a sprite extent of lim.
  function automatic logic in_window(input int v, input int lim);
    return (v >= 0) && (v < lim);
  endfunction

endpackage

// File: rtl/sprite_line_buf.sv
// One-row sprite line buffer: SPR_W x PIX_W register file with one write port
// and one registered read port that returns the transparent index when not enabled.
module sprite_line_buf
  import sprite_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(SPR_W)-1:0] waddr,
  input  logic [PIX_W-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(SPR_W)-1:0] raddr,
  output logic [PIX_W-1:0]         rdata
);

  logic [PIX_W-1:0] mem [SPR_W];

  // NOTE: the storage array has no reset; every entry is rewritten by a fetch
  // before line_hit lets the display path read it, so a reset would only cost flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata <= '0;
    else          rdata <= re ? mem[raddr] : PIX_W'(TRANSPARENT_IDX);
  end

endmodule

// File: rtl/sprite_line_fetch.sv
// Sprite ROM initiator: fetches one sprite row during hblank into a line buffer
// and serves colour indices during active video. Optional macro: SPRITE_FLIP_EN.
module sprite_line_fetch
  import sprite_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEF,
  parameter int SPR_H  = SPR_H_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = 10,
  parameter int CRD_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [CRD_W-1:0]  next_y,
  input  logic [CRD_W-1:0]  spr_x,
  input  logic [CRD_W-1:0]  spr_y,
  input  logic              spr_en,
`ifdef SPRITE_FLIP_EN
  input  logic              spr_flip,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_q,
  input  logic [CRD_W-1:0]  draw_x,
  input  logic              draw_active,
  output logic [PIX_W-1:0]  pix_idx,
  output logic              pix_valid,
  output logic              busy,
  output logic              fetch_done
);

  localparam int IDX_W = $clog2(SPR_W);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(SPR_W - 1);

  fetch_state_t        state;
  logic [IDX_W-1:0]    k;
  logic [ADDR_W-1:0]   base;
  logic [CRD_W-1:0]    x_lat;
  logic                line_hit;
  logic                flip_lat;
  logic                flip_in;
  logic                cap_valid;
  logic [IDX_W-1:0]    cap_idx;

  // One extra bit keeps rows above / columns left of the sprite negative.
  logic signed [CRD_W:0] row;
  logic signed [CRD_W:0] col;
  logic                  row_hit;
  logic                  col_hit;
  logic [ADDR_W-1:0]     row_base;

  assign row      = $signed({1'b0, next_y}) - $signed({1'b0, spr_y});
  assign row_hit  = spr_en && in_window(int'(row), SPR_H);
  assign row_base = ADDR_W'(row) * ADDR_W'(SPR_W);

`ifdef SPRITE_FLIP_EN
  assign flip_in = spr_flip;
`else
  assign flip_in = 1'b0;
`endif

  // NOTE: every state register here uses <= so all of them update from the
  // same pre-edge values; a blocking = would leak new values within the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      k          <= '0;
      base       <= '0;
      x_lat      <= '0;
      line_hit   <= 1'b0;
      flip_lat   <= 1'b0;
      rom_addr   <= '0;
      busy       <= 1'b0;
      fetch_done <= 1'b0;
      cap_valid  <= 1'b0;
      cap_idx    <= '0;
    end else begin
      fetch_done <= 1'b0;
      cap_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (line_start) begin
            x_lat    <= spr_x;
            base     <= row_base;
            flip_lat <= flip_in;
            line_hit <= 1'b0;
            if (row_hit) begin
              state    <= FETCH;
              k        <= '0;
              rom_addr <= row_base;
              busy     <= 1'b1;
            end
          end
        end
        FETCH: begin
          // The ROM answers one cycle later, so the write slot trails k by one.
          cap_valid <= 1'b1;
          cap_idx   <= flip_lat ? (LAST_K - k) : k;
          if (k == LAST_K) begin
            state <= DRAIN;
          end else begin
            k        <= k + 1'b1;
            rom_addr <= base + ADDR_W'(k) + ADDR_W'(1);
          end
        end
        DRAIN: begin
          state      <= IDLE;
          busy       <= 1'b0;
          fetch_done <= 1'b1;
          line_hit   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign col     = $signed({1'b0, draw_x}) - $signed({1'b0, x_lat});
  assign col_hit = draw_active && line_hit && in_window(int'(col), SPR_W);

  sprite_line_buf #(
    .SPR_W (SPR_W),
    .PIX_W (PIX_W)
  ) u_line_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (cap_valid),
    .waddr   (cap_idx),
    .wdata   (rom_q),
    .re      (col_hit),
    .raddr   (col[IDX_W-1:0]),
    .rdata   (pix_idx)
  );

  // The read port already forces index 0 outside the sprite.
  assign pix_valid = (pix_idx != PIX_W'(TRANSPARENT_IDX));

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Scoreboard bench for sprite_line_fetch: stimulus pushes expected ROM addresses
// and pixels into queues, a monitor pops and compares them as the DUT presents them.
module tb_sprite_line_fetch;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       line_start;
  logic [9:0] next_y, spr_x, spr_y;
  logic       spr_en;
`ifdef SPRITE_FLIP_EN
  logic       spr_flip;
`endif
  logic [9:0] rom_addr;
  logic [2:0] rom_q;
  logic [9:0] draw_x;
  logic       draw_active;
  logic [2:0] pix_idx;
  logic       pix_valid;
  logic       busy;
  logic       fetch_done;

  int total  = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] idx;
    logic       v;
    int         x;
  } pix_exp_t;

  pix_exp_t    pix_q[$];
  int unsigned addr_q[$];
  logic [2:0]  rom [1024];

  always #5 clk = ~clk;

  // Registered ROM, one cycle of latency.
  always @(posedge clk) rom_q <= rom[rom_addr];

  sprite_line_fetch dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .line_start  (line_start),
    .next_y      (next_y),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_en      (spr_en),
`ifdef SPRITE_FLIP_EN
    .spr_flip    (spr_flip),
`endif
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .draw_x      (draw_x),
    .draw_active (draw_active),
    .pix_idx     (pix_idx),
    .pix_valid   (pix_valid),
    .busy        (busy),
    .fetch_done  (fetch_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pixels are compared one cycle after their draw_x was driven,
  // ROM addresses whenever a fetch is presenting one.
  initial begin
    pix_exp_t    e;
    int unsigned a;
    forever begin
      @(posedge clk);
      #1;
      if (pix_q.size() > 0) begin
        e = pix_q.pop_front();
        check($sformatf("pix_idx@x=%0d", e.x), 32'(pix_idx), 32'(e.idx));
        check($sformatf("pix_valid@x=%0d", e.x), 32'(pix_valid), 32'(e.v));
      end
      if (busy && addr_q.size() > 0) begin
        a = addr_q.pop_front();
        check("rom_addr", 32'(rom_addr), a);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // One line_start, optionally a second ignored pulse glitch_at cycles later.
  task automatic run_line(input int ny, input int sy, input int sx, input bit en,
                          input bit flip, input bit exp_hit, input int glitch_at);
    int lat = 0, busy_cnt = 0, dones = 0;
    @(negedge clk);
    next_y = 10'(ny); spr_y = 10'(sy); spr_x = 10'(sx); spr_en = en;
`ifdef SPRITE_FLIP_EN
    spr_flip = flip;
`else
    if (flip) $display("note: flip requested in a build without SPRITE_FLIP_EN");
`endif
    line_start = 1'b1;
    if (exp_hit)
      for (int c = 0; c < 32; c++) addr_q.push_back(unsigned'((ny - sy) * 32 + c));
    @(negedge clk);
    line_start = 1'b0;
    if (busy) busy_cnt++;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (fetch_done) begin
        dones++;
        if (lat == 0) lat = i;
      end
      if (busy) busy_cnt++;
      if (glitch_at != 0 && i == glitch_at) begin
        next_y = 10'(sy + 10); spr_x = 10'(sx + 100); line_start = 1'b1;
      end
      if (glitch_at != 0 && i == glitch_at + 1) line_start = 1'b0;
    end
    if (exp_hit) begin
      check("fetch_latency", lat, 33);
      check("busy_cycles", busy_cnt, 33);
      check("fetch_done_count", dones, 1);
    end else begin
      check("miss_busy_cycles", busy_cnt, 0);
      check("miss_fetch_done_count", dones, 0);
    end
    check("addr_q_drained", addr_q.size(), 0);
  endtask

  // Sweep a full 640-pixel line plus one inactive pixel; model from the bench ROM.
  task automatic sweep(input int sx, input int base, input bit hit, input bit flip);
    logic [2:0] m;
    int col;
    for (int x = 0; x <= 640; x++) begin
      @(negedge clk);
      draw_active = (x < 640);
      draw_x = (x < 640) ? 10'(x) : 10'd0;
      col = x - sx;
      m = 3'd0;
      if (hit && x < 640 && col >= 0 && col < 32)
        m = flip ? rom[base + 31 - col] : rom[base + col];
      pix_q.push_back('{m, (m != 3'd0), x});
    end
    @(negedge clk);
    draw_active = 1'b0;
    draw_x = '0;
    repeat (2) @(posedge clk);
    #2;
    check("pix_q_drained", pix_q.size(), 0);
  endtask

  initial begin
    int busy_seen, dones;
    for (int i = 0; i < 1024; i++) rom[i] = 3'd0;
    for (int c = 0; c < 32; c++) begin
      rom[160 + c] = 3'd5;
      rom[192 + c] = (c < 4) ? 3'd0 : 3'((c % 7) + 1);
      rom[224 + c] = 3'(c % 8);
    end
    reset_n = 1'b0; line_start = 1'b0; next_y = '0; spr_x = '0; spr_y = '0;
    spr_en = 1'b0; draw_x = '0; draw_active = 1'b0;
`ifdef SPRITE_FLIP_EN
    spr_flip = 1'b0;
`endif
    #12;
    check("reset_pix_idx", 32'(pix_idx), 0);
    check("reset_pix_valid", 32'(pix_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_fetch_done", 32'(fetch_done), 0);
    check("reset_rom_addr", 32'(rom_addr), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Row 5 of an all-5 sprite at x=200.
    run_line(105, 100, 200, 1'b1, 1'b0, 1'b1, 0);
    sweep(200, 160, 1'b1, 1'b0);

    // Lines just above and just below the sprite.
    run_line(99, 100, 200, 1'b1, 1'b0, 1'b0, 0);
    sweep(200, 160, 1'b0, 1'b0);
    run_line(132, 100, 200, 1'b1, 1'b0, 1'b0, 0);
    sweep(200, 160, 1'b0, 1'b0);

    // Disabled sprite on a row that would otherwise hit.
    run_line(105, 100, 200, 1'b0, 1'b0, 1'b0, 0);
    sweep(200, 160, 1'b0, 1'b0);

    // Transparent leading columns, sprite clipped by the right screen edge.
    run_line(106, 100, 620, 1'b1, 1'b0, 1'b1, 0);
    sweep(620, 192, 1'b1, 1'b0);

    // Second line_start ten cycles into the fetch is ignored.
    run_line(105, 100, 200, 1'b1, 1'b0, 1'b1, 10);
    check("rom_addr_hold", 32'(rom_addr), 191);
    sweep(200, 160, 1'b1, 1'b0);

    // Reset mid-fetch: busy drops at once, no fetch_done, buffer not visible.
    @(negedge clk);
    next_y = 10'd105; spr_y = 10'd100; spr_x = 10'd200; spr_en = 1'b1; line_start = 1'b1;
    for (int c = 0; c < 32; c++) addr_q.push_back(unsigned'(160 + c));
    @(negedge clk);
    line_start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy), 0);
    check("async_reset_fetch_done", 32'(fetch_done), 0);
    addr_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    busy_seen = 0; dones = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_seen++;
      if (fetch_done) dones++;
    end
    check("post_reset_busy_cycles", busy_seen, 0);
    check("post_reset_fetch_done", dones, 0);
    sweep(200, 160, 1'b0, 1'b0);

`ifdef SPRITE_FLIP_EN
    // Mirrored row: draw_x=spr_x shows column 31, value 7.
    run_line(107, 100, 50, 1'b1, 1'b1, 1'b1, 0);
    sweep(50, 224, 1'b1, 1'b1);
    @(negedge clk);
    draw_active = 1'b1; draw_x = 10'd50;
    @(posedge clk);
    #1;
    check("flip_first_pixel", 32'(pix_idx), 7);
    @(negedge clk);
    draw_active = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("final_busy", 32'(busy), 0);
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
